next_block_queue: RTL and testbench
===================================

NEXT_BLOCK_QUEUE -- requirements
Module: next_block_queue

Interface
- REQ-001: Parameter DEPTH, default 4; number of queued preview blocks, range 2..8.
- REQ-002: Parameter GEN_LAT, default 3; cycles from a gen_en_o pulse until generator outputs carry the new block.
- REQ-003: Parameter REROLL_EN, default 1; 1 enables one reroll when a new block repeats the previous captured color.
- REQ-004: clk_i  in  1  single clock; all logic on rising edge.
- REQ-005: rst_n_i  in  1  reset, asynchronous, active-low.
- REQ-006: gen_en_o  out  1  advance pulse to generator enable.
- REQ-007: gen_block_i_data  in  64  generator block bitmap (4 rotations x 16 bits).
- REQ-008: gen_block_i_color  in  TETRIS_COLORS_WIDTH  generator color, 0 never valid.
- REQ-009: gen_block_i_rotation  in  2  generator start rotation.
- REQ-010: gen_block_i_x / gen_block_i_y  in  FIELD_COL_CNT_WIDTH+1 / FIELD_ROW_CNT_WIDTH+1 signed  spawn position.
- REQ-011: pop_i  in  1  game FSM request for the next block.
- REQ-012: pop_ack_o  out  1  one-cycle pulse: pop accepted, cur_block_o_* updated this edge.
- REQ-013: cur_block_o_data/color/rotation/x/y  out  same widths as gen_block_i_*  registered active block.
- REQ-014: preview_o_data / preview_o_color  out  64 / TETRIS_COLORS_WIDTH  queue head, for next-block display.
- REQ-015: cnt_o  out  $clog2(DEPTH+1)  current queue occupancy.

Function
- REQ-016: FSM states: ADVANCE, WAIT, CAPTURE, HOLD; state after reset is ADVANCE.
- REQ-017: ADVANCE: gen_en_o=1 for exactly one cycle, wait counter loaded with GEN_LAT-1; next state WAIT.
- REQ-018: WAIT: gen_en_o=0, counter decrements each cycle; at 0, next state CAPTURE.
- REQ-019: CAPTURE: sample all gen_block_i_* fields in one cycle; the generator is never sampled in any other state.
- REQ-020: CAPTURE reroll: REROLL_EN=1, reroll flag clear, sampled color equal to last captured color -> discard sample, set reroll flag, go ADVANCE.
- REQ-021: CAPTURE push: otherwise write sample at tail, record color as last captured, clear reroll flag; next state ADVANCE if occupancy after this edge < DEPTH, else HOLD.
- REQ-022: HOLD: gen_en_o=0; leave to ADVANCE on the cycle after occupancy drops below DEPTH.
- REQ-023: Pop accepted iff pop_i=1 and cnt_o>0, in any state; head copied into cur_block_o_*, entries shift toward head, pop_ack_o=1 that cycle.
- REQ-024: pop_i with cnt_o=0: ignored, no ack, cur_block_o_* unchanged; pop_i is not remembered.
- REQ-025: Push and pop same cycle: popped entry is old head; pushed entry lands at new tail; cnt_o unchanged; with cnt_o=1, pushed entry becomes head.
- REQ-026: preview_o_* = head entry combinationally from storage; with cnt_o=0, preview_o_data=0, preview_o_color=0.
- REQ-027: cnt_o never exceeds DEPTH and never underflows; cur_block_o_* and pop_ack_o have one-cycle latency from pop_i.
- REQ-028: Blocks leave the queue in capture order (FIFO), bit-exact with the sampled generator outputs.

Reset
- REQ-029: rst_n_i=0 asynchronously forces: state ADVANCE-entry with gen_en_o=0, cnt_o=0, pop_ack_o=0, cur_block_o_* = 0, preview_o_* = 0, last captured color = 0, reroll flag clear, wait counter 0.
- REQ-030: First gen_en_o pulse occurs in the first cycle after rst_n_i deasserts; reset mid-WAIT or mid-CAPTURE discards the in-flight sample.

Verification
- REQ-031: Reset release, generator model with GEN_LAT=3, no pops -> 4 gen_en_o pulses spaced >=4 cycles, cnt_o reaches 4, state HOLD, gen_en_o stays 0.
- REQ-032: Full queue, colors 2,5,1,7, pop_i one cycle -> pop_ack_o=1 next edge, cur_block_o_color=2, preview_o_color=5, cnt_o=3, gen_en_o pulses one cycle later.
- REQ-033: Generator returns color 3 then 3 again, REROLL_EN=1 -> second 3 discarded, one extra gen_en_o pulse; a third 3 is accepted (only one reroll).
- REQ-034: cnt_o=0 after reset, pop_i held high -> no ack until first CAPTURE; that block is pushed and popped in adjacent cycles, cnt_o returns to 0.
- REQ-035: cnt_o=1, pop_i asserted exactly on CAPTURE cycle -> cnt_o stays 1, cur gets old head, preview shows new sample.
- REQ-036: rst_n_i pulsed low mid-WAIT with cnt_o=3 -> outputs zero immediately, cnt_o=0, refill restarts after release.

Source files
------------

// File: rtl/next_block_queue.sv
// next_block_queue: pre-fetches upcoming tetromino blocks from a block generator and
// hands them to the game FSM in capture order.
//
// A four-state FSM (advance/wait/capture/hold) pulses the generator, waits out its
// latency, samples its outputs once and pushes the block into a shift-register FIFO.
// A sample that repeats the previously captured color can be rerolled once.
//
// Ports:
//   clk_i, rst_n_i              clock, asynchronous active-low reset
//   gen_en_o                    one-cycle advance pulse to the generator
//   gen_block_i_*               generator block (bitmap, color, rotation, spawn x/y)
//   pop_i                       request for the next block
//   pop_ack_o                   pop accepted; cur_block_o_* updated on the same edge
//   cur_block_o_*               registered active block
//   preview_o_data/color        queue head for the next-block display (0 when empty)
//   cnt_o                       queue occupancy
module next_block_queue #(
  parameter int unsigned DEPTH               = 4,
  parameter int unsigned GEN_LAT             = 3,
  parameter int unsigned REROLL_EN           = 1,
  parameter int unsigned TETRIS_COLORS_WIDTH = 3,
  parameter int unsigned FIELD_COL_CNT_WIDTH = 4,
  parameter int unsigned FIELD_ROW_CNT_WIDTH = 5,
  localparam int unsigned CNT_W              = $clog2(DEPTH + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  output logic                                  gen_en_o,
  input  logic [63:0]                           gen_block_i_data,
  input  logic [TETRIS_COLORS_WIDTH-1:0]        gen_block_i_color,
  input  logic [1:0]                            gen_block_i_rotation,
  input  logic signed [FIELD_COL_CNT_WIDTH:0]   gen_block_i_x,
  input  logic signed [FIELD_ROW_CNT_WIDTH:0]   gen_block_i_y,
  input  logic                                  pop_i,
  output logic                                  pop_ack_o,
  output logic [63:0]                           cur_block_o_data,
  output logic [TETRIS_COLORS_WIDTH-1:0]        cur_block_o_color,
  output logic [1:0]                            cur_block_o_rotation,
  output logic signed [FIELD_COL_CNT_WIDTH:0]   cur_block_o_x,
  output logic signed [FIELD_ROW_CNT_WIDTH:0]   cur_block_o_y,
  output logic [63:0]                           preview_o_data,
  output logic [TETRIS_COLORS_WIDTH-1:0]        preview_o_color,
  output logic [CNT_W-1:0]                      cnt_o
);

  localparam int unsigned CW    = TETRIS_COLORS_WIDTH;
  localparam int unsigned XW    = FIELD_COL_CNT_WIDTH + 1;
  localparam int unsigned YW    = FIELD_ROW_CNT_WIDTH + 1;
  localparam int unsigned LAT_W = (GEN_LAT > 1) ? $clog2(GEN_LAT) : 1;

  typedef struct packed {
    logic [63:0]          data;
    logic [CW-1:0]        color;
    logic [1:0]           rotation;
    logic signed [XW-1:0] x;
    logic signed [YW-1:0] y;
  } entry_t;

  typedef enum logic [1:0] {StAdvance, StWait, StCapture, StHold} state_e;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     last_color_q, last_color_d;
  logic              reroll_q, reroll_d;
  entry_t            cur_q;
  logic              pop_ack_q;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];

  entry_t            sample;
  logic              pop_ok;
  logic              push;
  logic              adv;
  logic [CNT_W-1:0]  cnt_popped;
  logic [CNT_W:0]    cnt_pushed;

  assign sample = '{data: gen_block_i_data, color: gen_block_i_color,
                    rotation: gen_block_i_rotation, x: gen_block_i_x, y: gen_block_i_y};

  assign pop_ok     = pop_i & (cnt_q != '0);
  assign cnt_popped = cnt_q - CNT_W'(pop_ok);
  // Occupancy after this edge if the current sample is pushed.
  assign cnt_pushed = {1'b0, cnt_popped} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_d      = push ? cnt_pushed[CNT_W-1:0] : cnt_popped;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    last_color_d = last_color_q;
    reroll_d     = reroll_q;
    push         = 1'b0;
    adv          = 1'b0;
    case (state_q)
      StAdvance: begin
        adv     = 1'b1;
        wait_d  = LAT_W'(GEN_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == '0) begin
          state_d = StCapture;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      StCapture: begin
        if ((REROLL_EN != 0) && !reroll_q && (sample.color == last_color_q)) begin
          // Only one reroll per block; the flag forces acceptance next time.
          reroll_d = 1'b1;
          state_d  = StAdvance;
        end else begin
          push         = 1'b1;
          last_color_d = sample.color;
          reroll_d     = 1'b0;
          state_d      = (cnt_pushed < (CNT_W + 1)'(DEPTH)) ? StAdvance : StHold;
        end
      end
      StHold: begin
        if (cnt_q < CNT_W'(DEPTH)) state_d = StAdvance;
      end
      default: state_d = StAdvance;
    endcase
  end

  // Shift toward the head on pop; a push lands at the tail of the post-pop queue.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (pop_ok) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        mem_d[i] = mem_q[i + 1];
      end
    end
    if (push) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (cnt_popped == CNT_W'(i)) mem_d[i] = sample;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StAdvance;
      wait_q       <= '0;
      cnt_q        <= '0;
      last_color_q <= '0;
      reroll_q     <= 1'b0;
      cur_q        <= '0;
      pop_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      cnt_q        <= cnt_d;
      last_color_q <= last_color_d;
      reroll_q     <= reroll_d;
      pop_ack_q    <= pop_ok;
      if (pop_ok) cur_q <= mem_q[0];
    end
  end

  // Storage contents are only visible through cnt_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Gate with reset so the advance state does not pulse the generator while held.
  assign gen_en_o = adv & rst_n_i;

  assign pop_ack_o            = pop_ack_q;
  assign cur_block_o_data     = cur_q.data;
  assign cur_block_o_color    = cur_q.color;
  assign cur_block_o_rotation = cur_q.rotation;
  assign cur_block_o_x        = cur_q.x;
  assign cur_block_o_y        = cur_q.y;
  assign preview_o_data       = (cnt_q != '0) ? mem_q[0].data : '0;
  assign preview_o_color      = (cnt_q != '0) ? mem_q[0].color : '0;
  assign cnt_o                = cnt_q;

endmodule

// File: tb/tb_next_block_queue.sv
// tb_next_block_queue: randomized bench for next_block_queue with a latency-accurate
// generator model and a cycle-level queue reference model built from queue operations.
module tb_next_block_queue;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned GEN_LAT   = 3;
  localparam int unsigned REROLL_EN = 1;
  localparam int unsigned CW        = 3;
  localparam int unsigned XW        = 5;
  localparam int unsigned YW        = 6;

  typedef struct packed {
    logic [63:0]   data;
    logic [CW-1:0] color;
    logic [1:0]    rot;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } blk_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pop;
  logic          gen_en;
  logic          pop_ack;
  logic [63:0]   cur_data;
  logic [CW-1:0] cur_color;
  logic [1:0]    cur_rot;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [63:0]   preview_data;
  logic [CW-1:0] preview_color;
  logic [2:0]    cnt;
  blk_t          gen_cur;

  next_block_queue #(
    .DEPTH              (DEPTH),
    .GEN_LAT            (GEN_LAT),
    .REROLL_EN          (REROLL_EN),
    .TETRIS_COLORS_WIDTH(CW),
    .FIELD_COL_CNT_WIDTH(XW - 1),
    .FIELD_ROW_CNT_WIDTH(YW - 1)
  ) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .gen_en_o            (gen_en),
    .gen_block_i_data    (gen_cur.data),
    .gen_block_i_color   (gen_cur.color),
    .gen_block_i_rotation(gen_cur.rot),
    .gen_block_i_x       (gen_cur.x),
    .gen_block_i_y       (gen_cur.y),
    .pop_i               (pop),
    .pop_ack_o           (pop_ack),
    .cur_block_o_data    (cur_data),
    .cur_block_o_color   (cur_color),
    .cur_block_o_rotation(cur_rot),
    .cur_block_o_x       (cur_x),
    .cur_block_o_y       (cur_y),
    .preview_o_data      (preview_data),
    .preview_o_color     (preview_color),
    .cnt_o               (cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  blk_t          mq[$];
  blk_t          m_cur;
  bit            m_ack;
  bit            m_hold;
  bit            m_rr;
  logic [CW-1:0] m_last;
  int            cyc;
  int            next_adv;
  int            cap_at;
  int            hits;
  // Generator model state.
  int            gen_delay;
  int            force_colors[$];
  logic [CW-1:0] last_gen;
  // Pulse statistics from the DUT.
  int            pulse_cnt;
  int            last_pulse;
  int            min_gap;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_block(output blk_t b);
    b.data = {$urandom, $urandom};
    if (force_colors.size() > 0) b.color = CW'(force_colors.pop_front());
    else if (last_gen != 0 && $urandom_range(9) < 4) b.color = last_gen;
    else b.color = CW'($urandom_range(7, 1));
    b.rot = 2'($urandom);
    b.x   = XW'($urandom);
    b.y   = YW'($urandom);
    last_gen = b.color;
  endtask

  // New block shows up GEN_LAT cycles after the pulse cycle.
  task automatic gen_tick(input bit pulse);
    blk_t b;
    if (gen_delay > 0) begin
      gen_delay--;
      if (gen_delay == 0) begin
        new_block(b);
        gen_cur = b;
      end
    end
    if (pulse) gen_delay = GEN_LAT;
  endtask

  task automatic model_edge(input bit pop_val);
    bit   do_pop;
    bit   do_push;
    int   size_now;
    blk_t s;
    size_now = mq.size();
    do_pop   = pop_val && size_now > 0;
    do_push  = 1'b0;
    s        = gen_cur;
    if (cyc == cap_at) begin
      if (REROLL_EN != 0 && !m_rr && s.color == m_last) begin
        m_rr     = 1'b1;
        next_adv = cyc + 1;
      end else begin
        do_push = 1'b1;
        m_last  = s.color;
        m_rr    = 1'b0;
        if (size_now - int'(do_pop) + 1 < int'(DEPTH)) next_adv = cyc + 1;
        else m_hold = 1'b1;
        if (do_pop && size_now == 1) hits++;
      end
    end else if (m_hold && size_now < int'(DEPTH)) begin
      m_hold   = 1'b0;
      next_adv = cyc + 1;
    end
    m_ack = do_pop;
    if (do_pop) m_cur = mq.pop_front();
    if (do_push) mq.push_back(s);
  endtask

  task automatic step(input bit pop_val);
    bit   gen_exp;
    blk_t cur_obs;
    blk_t head;
    gen_exp = (cyc == next_adv);
    cur_obs = {cur_data, cur_color, cur_rot, cur_x, cur_y};
    head    = (mq.size() > 0) ? mq[0] : '0;
    check_eq("gen_en", 96'(gen_en), 96'(gen_exp));
    check_eq("cnt", 96'(cnt), 96'(mq.size()));
    check_eq("pop_ack", 96'(pop_ack), 96'(m_ack));
    check_eq("cur_block", 96'(cur_obs), 96'(m_cur));
    check_eq("preview_data", 96'(preview_data), 96'(head.data));
    check_eq("preview_color", 96'(preview_color), 96'(head.color));
    if (gen_en) begin
      if (pulse_cnt > 0 && cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
      pulse_cnt++;
    end
    if (gen_exp) cap_at = cyc + int'(GEN_LAT) + 1;
    gen_tick(gen_exp);
    pop = pop_val;
    model_edge(pop_val);
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    pop   = 1'b0;
    #1;
    mq.delete();
    m_cur     = '0;
    m_ack     = 1'b0;
    m_hold    = 1'b0;
    m_rr      = 1'b0;
    m_last    = '0;
    next_adv  = -1000;
    cap_at    = -1000;
    gen_delay = 0;
    for (int k = 0; k < cycles; k++) begin
      check_eq("rst_gen_en", 96'(gen_en), 96'd0);
      check_eq("rst_cnt", 96'(cnt), 96'd0);
      check_eq("rst_pop_ack", 96'(pop_ack), 96'd0);
      check_eq("rst_cur", 96'({cur_data, cur_color, cur_rot, cur_x, cur_y}), 96'd0);
      check_eq("rst_preview", 96'({preview_data, preview_color}), 96'd0);
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    #1;
    next_adv  = cyc;
    pulse_cnt = 0;
    min_gap   = 1000;
  endtask

  initial begin
    bit found;
    rst_n    = 1'b0;
    pop      = 1'b0;
    gen_cur  = '0;
    cyc      = 0;
    hits     = 0;
    last_gen = '0;
    @(negedge clk);
    #1;

    // Fill from reset with known colors, no pops.
    do_reset(3);
    force_colors = '{2, 5, 1, 7};
    release_rst();
    repeat (40) step(1'b0);
    check_eq("fill_pulses", 96'(pulse_cnt), 96'd4);
    check_eq("fill_gap_ge4", 96'(min_gap >= 4), 96'd1);
    check_eq("fill_cnt", 96'(cnt), 96'd4);
    check_eq("hold_gen_en", 96'(gen_en), 96'd0);

    // Single pop from a full queue.
    step(1'b1);
    check_eq("pop1_ack", 96'(pop_ack), 96'd1);
    check_eq("pop1_cur_color", 96'(cur_color), 96'd2);
    check_eq("pop1_preview_color", 96'(preview_color), 96'd5);
    check_eq("pop1_cnt", 96'(cnt), 96'd3);
    check_eq("pop1_gen_en_quiet", 96'(gen_en), 96'd0);
    step(1'b0);
    check_eq("pop1_gen_en_pulse", 96'(gen_en), 96'd1);
    repeat (10) step(1'b0);

    // Reroll: 3, 3 (discarded), 3 (accepted), 4, 6.
    do_reset(2);
    force_colors = '{3, 3, 3, 4, 6};
    release_rst();
    repeat (40) step(1'b0);
    check_eq("reroll_pulses", 96'(pulse_cnt), 96'd5);
    check_eq("reroll_cnt", 96'(cnt), 96'd4);
    check_eq("reroll_head", 96'(preview_color), 96'd3);
    repeat (4) step(1'b1);
    repeat (10) step(1'b0);

    // pop_i held high from reset release.
    do_reset(2);
    pop = 1'b1;
    release_rst();
    repeat (60) step(1'b1);

    // Pop exactly on capture cycles.
    do_reset(2);
    force_colors = '{1, 2, 3, 4, 5, 6};
    hits = 0;
    release_rst();
    for (int k = 0; k < 60; k++) step(cyc == cap_at);
    check_eq("push_pop_same_cycle_seen", 96'(hits > 0), 96'd1);

    // Reset while waiting on the generator with three queued blocks.
    do_reset(2);
    release_rst();
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (mq.size() == 3 && cyc > cap_at - int'(GEN_LAT) - 1 && cyc < cap_at) found = 1'b1;
      else step(1'b0);
    end
    check_eq("reach_wait_cnt3", 96'(found), 96'd1);
    do_reset(2);
    release_rst();
    repeat (60) step(1'b0);
    check_eq("refill_cnt", 96'(cnt), 96'd4);

    // Random pops.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(99) < ((k < 1500) ? 50 : 15));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
